mps_intl_latch: RTL

MPS_INTL_LATCH -- requirements
Module: mps_intl_latch

---
 rtl/mps_intl_pkg.sv | 15 +
 rtl/mps_intl_filter.sv | 45 ++++
 rtl/mps_intl_latch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mps_intl_pkg.sv
// Shared types and defaults for the analog interlock latch.
// Holds the FSM state enum, default sizes and first-fault index width.
package mps_intl_pkg;

   localparam int CH_NUM_DEF = 18;
   localparam int DB_W_DEF   = 16;
   localparam int FF_W       = 5;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_TRIPPED  = 2'd1,
      ST_CLEARING = 2'd2
   } state_e;

endpackage

// File: rtl/mps_intl_filter.sv
// Per-channel debounce filter for one interlock input.
// Ports: clk_i, rst_ni, raw_i, mask_i, db_len_i (threshold), flag_o (filtered).
module mps_intl_filter #(
   parameter int DB_W = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            raw_i,
   input  logic            mask_i,
   input  logic [DB_W-1:0] db_len_i,
   output logic            flag_o
);

   logic            active;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] cnt_d;
   logic            flag_q;
   logic            flag_d;

   assign active = raw_i & ~mask_i;

   // The flag is registered so a zero threshold still gives one cycle of
   // latency. Comparing with >= lets a lowered threshold take effect at once.
   always_comb begin
      cnt_d  = '0;
      flag_d = 1'b0;
      if (active) begin
         flag_d = (cnt_q >= db_len_i);
         cnt_d  = (cnt_q >= db_len_i) ? db_len_i : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/mps_intl_latch.sv
// Analog interlock debounce, latch and clear FSM.
// Inputs: i_clk, i_rst (async low), i_raw_intl, i_intl_mask, i_db_len,
// i_intl_clr. Outputs: o_analog_intl, o_intl_any, o_clr_done, o_clr_fail,
// o_first_fault, o_first_valid, o_state.
// Macro MPS_INTL_FIRST_FAULT_EN enables first-fault capture.
module mps_intl_latch
   import mps_intl_pkg::*;
#(
   parameter int CH_NUM = CH_NUM_DEF,
   parameter int DB_W   = DB_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [CH_NUM-1:0] i_raw_intl,
   input  logic [CH_NUM-1:0] i_intl_mask,
   input  logic [DB_W-1:0]   i_db_len,
   input  logic              i_intl_clr,
   output logic [CH_NUM-1:0] o_analog_intl,
   output logic              o_intl_any,
   output logic              o_clr_done,
   output logic              o_clr_fail,
   output logic [FF_W-1:0]   o_first_fault,
   output logic              o_first_valid,
   output logic [1:0]        o_state
);

   logic [CH_NUM-1:0] flag;
   logic [CH_NUM-1:0] new_evt;
   logic [CH_NUM-1:0] latch_q;
   logic [CH_NUM-1:0] latch_d;
   state_e            state_q;
   state_e            state_d;
   logic              done_d;
   logic              done_q;
   logic              fail_d;
   logic              fail_q;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_filt
      mps_intl_filter #(
         .DB_W(DB_W)
      ) u_filt (
         .clk_i   (i_clk),
         .rst_ni  (i_rst),
         .raw_i   (i_raw_intl[g]),
         .mask_i  (i_intl_mask[g]),
         .db_len_i(i_db_len),
         .flag_o  (flag[g])
      );
   end

   assign new_evt = flag & ~i_intl_mask;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   // New events are OR-ed in after the clear so they win over it.
   always_comb begin
      state_d = state_q;
      latch_d = latch_q | new_evt;
      unique case (state_q)
         ST_NORMAL: begin
            if (|latch_d) state_d = ST_TRIPPED;
         end
         ST_TRIPPED: begin
            if (i_intl_clr) state_d = ST_CLEARING;
         end
         ST_CLEARING: begin
            latch_d = (latch_q & flag) | new_evt;
            state_d = (|latch_d) ? ST_TRIPPED : ST_NORMAL;
         end
         default: begin
            state_d = ST_NORMAL;
         end
      endcase
   end

   always_comb begin
      done_d = 1'b0;
      fail_d = 1'b0;
      unique case (state_q)
         ST_NORMAL: begin
            done_d = i_intl_clr;
         end
         ST_CLEARING: begin
            done_d = ~|latch_d;
            fail_d = |latch_d;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         latch_q <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         latch_q <= latch_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign o_analog_intl = latch_q;
   assign o_intl_any    = |latch_q;
   assign o_clr_done    = done_q;
   assign o_clr_fail    = fail_q;
   assign o_state       = state_q;

`ifdef MPS_INTL_FIRST_FAULT_EN
   logic [FF_W-1:0] ff_q;
   logic [FF_W-1:0] ff_idx;
   logic            fv_q;

   // Descending scan so the lowest newly latched index is kept.
   always_comb begin
      ff_idx = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (new_evt[i]) ff_idx = FF_W'(i);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ff_q <= '0;
         fv_q <= 1'b0;
      end else if (state_q == ST_NORMAL && state_d == ST_TRIPPED) begin
         ff_q <= ff_idx;
         fv_q <= 1'b1;
      end else if (done_d) begin
         ff_q <= '0;
         fv_q <= 1'b0;
      end
   end

   assign o_first_fault = ff_q;
   assign o_first_valid = fv_q;
`else
   assign o_first_fault = '0;
   assign o_first_valid = 1'b0;
`endif

endmodule
